// File: rtl/scarf_pkg.sv
// Shared types for the oversampled SCARF SPI slave.
// FSM state encoding, SPI mode bundle and sample-edge helper.
package scarf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Leading edge is rising when CPOL=0, so sampling is on rising iff CPOL==CPHA.
  function automatic logic sample_rising(input spi_mode_t m);
    return m.cpol == m.cpha;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchroniser for asynchronous pins into the clk domain.
// Reset value is parameterised so idle pin levels survive reset.
module synchronizer #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/scarf_os.sv
// Oversampled SCARF SPI slave, all logic in the clk domain.
// Define SCARF_TIMEOUT_EN to add the idle-sclk abort and timeout port.
module scarf_os
  import scarf_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ID_W        = 7,
  parameter int IDX_W       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] read_data_in,
  output logic              rd_req,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              data_out_finished,
  output logic [ID_W-1:0]   slave_id,
  output logic              rnw,
  output logic [IDX_W-1:0]  byte_index
`ifdef SCARF_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  localparam spi_mode_t  MODE     = '{cpol: 1'(CPOL), cpha: 1'(CPHA)};
  localparam logic       SMP_RISE = sample_rising(MODE);
  localparam int         CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [3:0] CAP_SEL  = 4'(1 << (RD_LAT - 1));
  localparam logic [2:0] PIN_RST  = {1'b1, 1'b0, 1'(CPOL)};

  logic [2:0] w_s2;
  logic [2:0] w_pins;

  synchronizer #(
    .W       (3),
    .RST_VAL (PIN_RST)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({ss_n, mosi, sclk}),
    .o_q (w_s2)
  );

  generate
    if (SYNC_STAGES > 2) begin : g_ext
      logic [2:0] r_ext [SYNC_STAGES-2];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES - 2; i++)
            r_ext[i] <= PIN_RST;
        end else begin
          r_ext[0] <= w_s2;
          for (int i = 1; i < SYNC_STAGES - 2; i++)
            r_ext[i] <= r_ext[i-1];
        end
      end
      assign w_pins = r_ext[SYNC_STAGES-3];
    end else begin : g_direct
      assign w_pins = w_s2;
    end
  endgenerate

  state_t            r_state;
  logic              r_sclk_d;
  logic              r_ss_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-2:0] r_rx;
  logic [DATA_W-1:0] r_tx;
  logic              r_miso;
  logic              r_oe;
  logic              r_rd_req;
  logic [2:0]        r_rd_pipe;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_fin;
  logic [ID_W-1:0]   r_sid;
  logic              r_rnw;
  logic [IDX_W-1:0]  r_bidx;

  logic              w_sclk;
  logic              w_mosi;
  logic              w_ss;
  logic              w_rise;
  logic              w_fall;
  logic              w_smp;
  logic              w_shf;
  logic              w_ss_fall;
  logic              w_last;
  logic              w_cap;
  logic              w_to_hit;
  logic [DATA_W-1:0] w_word;

  assign w_sclk    = w_pins[0];
  assign w_mosi    = w_pins[1];
  assign w_ss      = w_pins[2];
  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_smp     = SMP_RISE ? w_rise : w_fall;
  assign w_shf     = SMP_RISE ? w_fall : w_rise;
  assign w_ss_fall = ~w_ss & r_ss_d;
  assign w_word    = {r_rx, w_mosi};
  assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));
  // Capture fires RD_LAT edges after the edge that raised rd_req.
  assign w_cap     = |({r_rd_pipe, r_rd_req} & CAP_SEL);

`ifdef SCARF_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  assign w_to_hit = (r_state != IDLE) && !w_ss &&
                    (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      if (r_state == IDLE || w_rise || w_fall || w_to_hit)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sclk_d  <= 1'(CPOL);
      r_ss_d    <= 1'b1;
      r_cnt     <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_miso    <= 1'b0;
      r_oe      <= 1'b0;
      r_rd_req  <= 1'b0;
      r_rd_pipe <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_fin     <= 1'b1;
      r_sid     <= '0;
      r_rnw     <= 1'b0;
      r_bidx    <= '0;
    end else begin
      r_sclk_d  <= w_sclk;
      r_ss_d    <= w_ss;
      r_fin     <= w_ss;
      r_rd_req  <= 1'b0;
      r_valid   <= 1'b0;
      r_rd_pipe <= {r_rd_pipe[1:0], r_rd_req};
      // Deselect beats any sclk edge seen in the same cycle.
      if (w_ss || w_to_hit) begin
        r_state <= IDLE;
        r_oe    <= 1'b0;
        r_miso  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_ss_fall) begin
              r_state <= HDR;
              r_cnt   <= '0;
              r_rx    <= '0;
              r_tx    <= '0;
              r_bidx  <= '0;
              r_oe    <= 1'b1;
            end
          end
          HDR, DATA: begin
            if (w_shf) begin
              r_miso <= r_tx[DATA_W-1];
              r_tx   <= r_tx << 1;
            end else if (w_cap && r_state == DATA) begin
              r_tx <= read_data_in;
              if (CPHA == 0)
                r_miso <= read_data_in[DATA_W-1];
            end
            if (w_smp) begin
              r_rx <= w_word[DATA_W-2:0];
              if (w_last) begin
                r_cnt <= '0;
                if (r_state == HDR) begin
                  r_sid    <= w_word[ID_W-1:0];
                  r_rnw    <= w_word[DATA_W-1];
                  r_rd_req <= w_word[DATA_W-1];
                  r_state  <= DATA;
                end else begin
                  r_dout   <= w_word;
                  r_valid  <= 1'b1;
                  r_bidx   <= r_bidx + 1'b1;
                  r_rd_req <= r_rnw;
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign miso              = r_miso;
  assign miso_oe           = r_oe;
  assign rd_req            = r_rd_req;
  assign data_out          = r_dout;
  assign data_out_valid    = r_valid;
  assign data_out_finished = r_fin;
  assign slave_id          = r_sid;
  assign rnw               = r_rnw;
  assign byte_index        = r_bidx;

endmodule
